// File: rtl/rnd_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rnd_sched_pkg: shared widths, constants and FSM states for rnd_sched |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rnd_sched_pkg;

    localparam int               RND_W        = 13;
    localparam int               FRESH_SHIFTS = 13;
    localparam logic [RND_W-1:0] SEED_DEFAULT = 13'h000F;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Taps 12/3/2/0, new bit enters at the LSB.
    function automatic logic [RND_W-1:0] lfsr_next(input logic [RND_W-1:0] r);
        return {r[11:0], r[12] ^ r[3] ^ r[2] ^ r[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr13_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr13_core: 13-bit Fibonacci LFSR with shift enable and reseed      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr13_core
    import rnd_sched_pkg::*;
#(
    parameter logic [RND_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [RND_W-1:0] i_load_val,
    output logic [RND_W-1:0] o_q
);

    logic [RND_W-1:0] r_q;

    // An all-zero seed would lock the LFSR, so it falls back to SEED.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= SEED;
        end else if (i_load) begin
            r_q <= (i_load_val == '0) ? SEED : i_load_val;
        end else if (i_en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/rnd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rnd_sched: round-robin grant carrying a fully refreshed random value |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rnd_sched
    import rnd_sched_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter logic [RND_W-1:0] SEED    = SEED_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               lfsr_en,
    input  logic               seed_load,
    input  logic [RND_W-1:0]   seed_val,
    output logic [NUM_REQ-1:0] gnt,
    output logic [RND_W-1:0]   rnd_out,
    output logic               rnd_valid,
    output logic               fresh
);

    localparam int         IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] c_fresh_max = 4'(FRESH_SHIFTS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_fresh_cnt;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [RND_W-1:0]   r_rnd_out;
    logic [RND_W-1:0]   w_rnd_nxt;
    logic               r_rnd_valid;
    logic               w_valid_nxt;
    logic [RND_W-1:0]   w_lfsr;
    logic               w_decide;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;

    lfsr13_core #(
        .SEED       (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .i_en       (lfsr_en),
        .i_load     (seed_load),
        .i_load_val (seed_val),
        .o_q        (w_lfsr)
    );

    // Scan upward from the requester after the last winner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(r_last) + 1 + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_decide = (r_state == IDLE) && (req != '0) &&
                      (r_fresh_cnt == c_fresh_max) && !seed_load;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_rnd_nxt   = r_rnd_out;
        case (r_state)
            IDLE: begin
                if (w_decide) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = NUM_REQ'(1) << w_win;
                    w_valid_nxt = 1'b1;
                    w_rnd_nxt   = w_lfsr;
                end
            end
            GRANT: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rnd_out   <= '0;
            r_rnd_valid <= 1'b0;
            r_last      <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rnd_out   <= w_rnd_nxt;
            r_rnd_valid <= w_valid_nxt;
            if (w_decide) begin
                r_last <= w_win;
            end
        end
    end

    // Reseed and delivery both restart the freshness count; otherwise count shifts up to 13.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fresh_cnt <= '0;
        end else if (seed_load || w_decide) begin
            r_fresh_cnt <= '0;
        end else if (lfsr_en && (r_fresh_cnt != c_fresh_max)) begin
            r_fresh_cnt <= r_fresh_cnt + 4'd1;
        end
    end

    assign gnt       = r_gnt;
    assign rnd_out   = r_rnd_out;
    assign rnd_valid = r_rnd_valid;
    assign fresh     = (r_fresh_cnt == c_fresh_max);

endmodule
`default_nettype wire

// File: tb/tb_rnd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rnd_sched: directed self-checking bench for rnd_sched             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rnd_sched;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic        lfsr_en;
    logic        seed_load;
    logic [12:0] seed_val;
    logic [3:0]  gnt;
    logic [12:0] rnd_out;
    logic        rnd_valid;
    logic        fresh;

    int          n_vec;
    int          n_err;
    int          n;
    logic [3:0]  seen;
    logic [3:0]  exp_g [0:4];

    rnd_sched #(
        .NUM_REQ   (4),
        .SEED      (13'h000F)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lfsr_en   (lfsr_en),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .fresh     (fresh)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until a grant appears, bounded at 40 cycles.
    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (gnt == '0 && cnt < 40);
    endtask

    function automatic logic [12:0] adv(input logic [12:0] v, input int steps);
        logic [12:0] r;
        r = v;
        for (int i = 0; i < steps; i++) r = {r[11:0], r[12] ^ r[3] ^ r[2] ^ r[0]};
        return r;
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_g     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset     = 1'b1;
        req       = 4'b0001;
        lfsr_en   = 1'b1;
        seed_load = 1'b0;
        seed_val  = '0;
        #2;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_valid", rnd_valid, 1'b0);
        chk("rst_rnd", rnd_out, 13'h0000);
        chk("rst_fresh", fresh, 1'b0);

        // First grant lands on edge 14 after release.
        tick();
        reset = 1'b0;
        repeat (13) tick();
        chk("e13_gnt", gnt, 4'b0000);
        chk("e13_fresh", fresh, 1'b1);
        tick();
        chk("e14_gnt", gnt, 4'b0001);
        chk("e14_valid", rnd_valid, 1'b1);
        chk("e14_rnd", rnd_out, 13'h1FF4);
        chk("e14_fresh", fresh, 1'b0);
        tick();
        chk("e15_gnt", gnt, 4'b0000);
        chk("e15_valid", rnd_valid, 1'b0);
        chk("e15_rnd_hold", rnd_out, 13'h1FF4);

        // All requesters high: rotation and 14-cycle spacing.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(n);
            chk("rr_space", n, 14);
            chk("rr_gnt", gnt, exp_g[k]);
            chk("rr_rnd", rnd_out, adv(13'h000F, 13 + 14 * k));
        end

        // Last winner 0, req 0101: 2 then wrap to 0.
        req = 4'b0101;
        wait_gnt(n);
        chk("p_space", n, 14);
        chk("p_gnt2", gnt, 4'b0100);
        wait_gnt(n);
        chk("p_gnt0", gnt, 4'b0001);

        // No requests: no grant, then a request with fresh data wins next edge.
        req  = 4'b0000;
        seen = '0;
        repeat (20) begin
            tick();
            seen = seen | gnt;
        end
        chk("idle_nognt", seen, 4'b0000);
        chk("idle_fresh", fresh, 1'b1);
        req = 4'b0010;
        tick();
        chk("imm_gnt", gnt, 4'b0010);
        chk("imm_valid", rnd_valid, 1'b1);

        // seed_load beats a pending decision, then 14 cycles to the next grant.
        req = 4'b0000;
        repeat (14) tick();
        chk("pre_seed_fresh", fresh, 1'b1);
        req       = 4'b0001;
        seed_load = 1'b1;
        seed_val  = 13'h0000;
        tick();
        seed_load = 1'b0;
        chk("seed_nognt", gnt, 4'b0000);
        chk("seed_fresh", fresh, 1'b0);
        wait_gnt(n);
        chk("seed_space", n, 14);
        chk("seed_gnt", gnt, 4'b0001);
        chk("seed_rnd", rnd_out, 13'h1FF4);

        // Reseed during GRANT keeps the pulse and uses the supplied value.
        seed_load = 1'b1;
        seed_val  = 13'h0001;
        req       = 4'b0000;
        #2;
        chk("sg_gnt_kept", gnt, 4'b0001);
        chk("sg_valid_kept", rnd_valid, 1'b1);
        tick();
        seed_load = 1'b0;
        chk("sg_gnt_end", gnt, 4'b0000);
        chk("sg_rnd_hold", rnd_out, 13'h1FF4);
        chk("sg_fresh", fresh, 1'b0);
        req = 4'b0100;
        wait_gnt(n);
        chk("sv_space", n, 14);
        chk("sv_gnt", gnt, 4'b0100);
        chk("sv_rnd", rnd_out, adv(13'h0001, 13));

        // LFSR disabled from reset: never a grant until shifting starts.
        reset   = 1'b1;
        lfsr_en = 1'b0;
        req     = 4'b0001;
        #2;
        reset = 1'b0;
        seen  = '0;
        repeat (30) begin
            tick();
            seen = seen | gnt;
        end
        chk("noen_nognt", seen, 4'b0000);
        chk("noen_fresh", fresh, 1'b0);
        lfsr_en = 1'b1;
        wait_gnt(n);
        chk("en_space", n, 14);
        chk("en_gnt", gnt, 4'b0001);
        chk("en_rnd", rnd_out, 13'h1FF4);

        // Reset inside a GRANT cycle clears outputs without a clock edge.
        req = 4'b1111;
        wait_gnt(n);
        chk("ar_pre_gnt", gnt, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_gnt", gnt, 4'b0000);
        chk("ar_valid", rnd_valid, 1'b0);
        chk("ar_rnd", rnd_out, 13'h0000);
        #1;
        reset = 1'b0;
        wait_gnt(n);
        chk("ar_space", n, 14);
        chk("ar_gnt0", gnt, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
